// File: rtl/jtcps1_scroll_sched_if.sv
// jtcps1_scroll_sched_if
// VRAM request/arbitration bundle between the three scroll tilemap engines,
// the line scheduler/arbiter and the SDRAM VRAM client port.
// The master side is the engine/SDRAM environment.
// The slave side is the scheduler, which owns the shared read port.
// mem_data is broadcast unmodified, so engines read it straight from the bundle.

interface jtcps1_scroll_sched_if #(
    parameter int AW = 23
);
    logic [2:0]  req_cs;
    logic [AW:1] req_addr0;
    logic [AW:1] req_addr1;
    logic [AW:1] req_addr2;
    logic [2:0]  req_ok;
    logic        mem_cs;
    logic [AW:1] mem_addr;
    logic [15:0] mem_data;
    logic        mem_ok;
    logic [1:0]  gnt;

    modport master (
        output req_cs,
        output req_addr0,
        output req_addr1,
        output req_addr2,
        output mem_data,
        output mem_ok,
        input  req_ok,
        input  mem_cs,
        input  mem_addr,
        input  gnt
    );

    modport slave (
        input  req_cs,
        input  req_addr0,
        input  req_addr1,
        input  req_addr2,
        input  mem_ok,
        output req_ok,
        output mem_cs,
        output mem_addr,
        output gnt
    );
endinterface

// File: rtl/jtcps1_scroll_sched.sv
// jtcps1_scroll_sched
// Per-line start sequencing for the 8x8/16x16/32x32 scroll engines and a
// round-robin VRAM arbiter whose grants last a whole access burst.
// Optional feature: define JTCPS1_SCHED_WDOG_EN to add a per-grant watchdog
// that forcibly releases an owner that waits WDOG cycles without mem_ok.

module jtcps1_scroll_sched #(
    parameter int AW   = 23,
    parameter int WDOG = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    line_start_i,
    input  logic [2:0]              layer_en_i,
    output logic [2:0]              start_o,
    input  logic [2:0]              done_i,
    output logic [2:0]              busy_o,
    output logic                    overrun_o,
    jtcps1_scroll_sched_if.slave    bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arbState_t;

    // ------------------------------------------------------------------
    // Line sequencing state
    // ------------------------------------------------------------------
    logic [2:0]      start_q, start_d;
    logic [2:0]      busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [2:0][1:0] age_q, age_d;

    logic [2:0]      finished;
    logic [2:0]      stillBusy;
    logic [2:0]      launch;

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    arbState_t       state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      lastOwner_q, lastOwner_d;
    logic [2:0]      reqEff;
    logic            ownerReq;
    logic            wdogTrip;

    // Round-robin choice: first requester after the last owner, wrapping.
    function automatic logic [1:0] rrPick(input logic [1:0] last,
                                          input logic [2:0] req);
        logic [1:0] c0;
        logic [1:0] c1;
        c0 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c1 = (c0 == 2'd2) ? 2'd0 : c0 + 2'd1;
        if (req[c0]) begin
            return c0;
        end else if (req[c1]) begin
            return c1;
        end else begin
            return last;
        end
    endfunction

    assign ownerReq = bus.req_cs[owner_q];

`ifdef JTCPS1_SCHED_WDOG_EN
    localparam int WdW = (WDOG < 2) ? 1 : $clog2(WDOG + 1);

    logic [WdW-1:0] wdogCnt_q, wdogCnt_d;
    logic [2:0]     lockout_q, lockout_d;

    // An engine that lost the bus to the watchdog is ignored until its req_cs drops.
    assign reqEff = bus.req_cs & ~lockout_q;

    // Watchdog: count consecutive owned cycles without data, trip at the limit.
    always_comb begin
        wdogCnt_d = '0;
        wdogTrip  = 1'b0;
        lockout_d = lockout_q & bus.req_cs;
        if (state_q == ST_OWN && ownerReq && !bus.mem_ok) begin
            if (wdogCnt_q == WdW'(WDOG - 1)) begin
                wdogTrip           = 1'b1;
                lockout_d[owner_q] = 1'b1;
            end else begin
                wdogCnt_d = wdogCnt_q + 1'b1;
            end
        end
    end

    // Watchdog counter and lockout registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdogCnt_q <= '0;
            lockout_q <= '0;
        end else begin
            wdogCnt_q <= wdogCnt_d;
            lockout_q <= lockout_d;
        end
    end
`else
    // Without the watchdog every raised req_cs is eligible and no release is forced.
    assign reqEff   = bus.req_cs;
    assign wdogTrip = (WDOG < 0);
`endif

    // Done qualification, start pulses, busy and overrun next-state.
    always_comb begin
        finished  = '0;
        stillBusy = '0;
        launch    = '0;
        age_d     = age_q;
        for (int i = 0; i < 3; i++) begin
            // age >= 2 means the stale done level from before start has gone
            finished[i]  = busy_q[i] & done_i[i] & age_q[i][1];
            stillBusy[i] = busy_q[i] & ~finished[i];
            launch[i]    = line_start_i & layer_en_i[i] & ~stillBusy[i];
            if (launch[i]) begin
                age_d[i] = 2'd0;
            end else if (busy_q[i] && age_q[i] != 2'd3) begin
                age_d[i] = age_q[i] + 2'd1;
            end
        end
        start_d   = launch;
        busy_d    = stillBusy | launch;
        overrun_d = overrun_q | (line_start_i & (|stillBusy)) | wdogTrip;
    end

    // Line sequencing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q   <= '0;
            busy_q    <= '0;
            overrun_q <= 1'b0;
            age_q     <= '0;
        end else begin
            start_q   <= start_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            age_q     <= age_d;
        end
    end

    // Arbiter next-state: grant from IDLE, release when the owner drops req_cs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        case (state_q)
            ST_IDLE: begin
                if (|reqEff) begin
                    state_d = ST_OWN;
                    owner_d = rrPick(lastOwner_q, reqEff);
                end
            end
            ST_OWN: begin
                if (!ownerReq || wdogTrip) begin
                    state_d     = ST_IDLE;
                    lastOwner_d = owner_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbiter registers; engine 0 gets first priority after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 2'd0;
            lastOwner_q <= 2'd2;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
        end
    end

    // Bus outputs: the owner's chip select and address pass straight through,
    // so code/attribute address changes inside a burst need no extra cycle.
    always_comb begin
        bus.mem_cs   = 1'b0;
        bus.mem_addr = '0;
        bus.req_ok   = '0;
        bus.gnt      = 2'd0;
        if (state_q == ST_OWN) begin
            bus.mem_cs          = ownerReq;
            bus.req_ok[owner_q] = bus.mem_ok;
            bus.gnt             = owner_q + 2'd1;
            case (owner_q)
                2'd0:    bus.mem_addr = bus.req_addr0;
                2'd1:    bus.mem_addr = bus.req_addr1;
                default: bus.mem_addr = bus.req_addr2;
            endcase
        end
    end

    assign start_o   = start_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_jtcps1_scroll_sched.sv
// tb_jtcps1_scroll_sched
// Directed vector table for line sequencing and arbitration, plus
// hand-written sequences for long ownership, async reset and coincident events.

module tb_jtcps1_scroll_sched;

    logic       clk;
    logic       rst_n;
    logic       lineStart;
    logic [2:0] layerEn;
    logic [2:0] startOut;
    logic [2:0] done;
    logic [2:0] busyOut;
    logic       overrunOut;

    int checks;
    int errors;

    jtcps1_scroll_sched_if #(.AW(23)) bus ();

    jtcps1_scroll_sched #(.AW(23), .WDOG(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .line_start_i (lineStart),
        .layer_en_i   (layerEn),
        .start_o      (startOut),
        .done_i       (done),
        .busy_o       (busyOut),
        .overrun_o    (overrunOut),
        .bus          (bus)
    );

    typedef struct {
        logic        ls;
        logic [2:0]  en;
        logic [2:0]  dn;
        logic [2:0]  req;
        logic [23:1] a1;
        logic        ok;
        logic [2:0]  eStart;
        logic [2:0]  eBusy;
        logic        eOv;
        logic [1:0]  eGnt;
        logic        eCs;
        logic [23:1] eAddr;
        logic [2:0]  eOk;
    } vec_t;

    localparam logic [23:1] A0 = 23'h000100;
    localparam logic [23:1] A2 = 23'h000300;

    vec_t tbl[26];
    vec_t post[8];

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ls, input logic [2:0] en, input logic [2:0] dn,
                                input logic [2:0] req, input logic [23:1] a1, input logic ok,
                                input logic [2:0] eStart, input logic [2:0] eBusy, input logic eOv,
                                input logic [1:0] eGnt, input logic eCs, input logic [23:1] eAddr,
                                input logic [2:0] eOk);
        vec_t v;
        v.ls = ls; v.en = en; v.dn = dn; v.req = req; v.a1 = a1; v.ok = ok;
        v.eStart = eStart; v.eBusy = eBusy; v.eOv = eOv; v.eGnt = eGnt;
        v.eCs = eCs; v.eAddr = eAddr; v.eOk = eOk;
        return v;
    endfunction

    task automatic checkField(input string nm, input int row, input logic [31:0] act,
                              input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        lineStart     = v.ls;
        layerEn       = v.en;
        done          = v.dn;
        bus.req_cs    = v.req;
        bus.req_addr1 = v.a1;
        bus.mem_ok    = v.ok;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int row, input vec_t v);
        checkField({tag, "_start"}, row, 32'(startOut), 32'(v.eStart));
        checkField({tag, "_busy"}, row, 32'(busyOut), 32'(v.eBusy));
        checkField({tag, "_overrun"}, row, 32'(overrunOut), 32'(v.eOv));
        checkField({tag, "_gnt"}, row, 32'(bus.gnt), 32'(v.eGnt));
        checkField({tag, "_mem_cs"}, row, 32'(bus.mem_cs), 32'(v.eCs));
        checkField({tag, "_mem_addr"}, row, 32'(bus.mem_addr), 32'(v.eAddr));
        checkField({tag, "_req_ok"}, row, 32'(bus.req_ok), 32'(v.eOk));
    endtask

    task automatic checkAllReset(input string tag);
        checkField({tag, "_start"}, 0, 32'(startOut), 32'd0);
        checkField({tag, "_busy"}, 0, 32'(busyOut), 32'd0);
        checkField({tag, "_overrun"}, 0, 32'(overrunOut), 32'd0);
        checkField({tag, "_gnt"}, 0, 32'(bus.gnt), 32'd0);
        checkField({tag, "_mem_cs"}, 0, 32'(bus.mem_cs), 32'd0);
        checkField({tag, "_mem_addr"}, 0, 32'(bus.mem_addr), 32'd0);
        checkField({tag, "_req_ok"}, 0, 32'(bus.req_ok), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        int holdBad;
        int relCyc;
        checks = 0;
        errors = 0;
        holdBad = 0;
        relCyc = 0;

        //              ls en      dn      req     a1         ok  start   busy    ov gnt cs addr        rok
        // line start with all engines, stale done masked for two cycles
        tbl[0]  = mk(1, 3'b111, 3'b111, 3'b000, 23'h1000, 0, 3'b111, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        tbl[1]  = mk(0, 3'b111, 3'b111, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        tbl[2]  = mk(0, 3'b111, 3'b111, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        tbl[3]  = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        tbl[4]  = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        tbl[5]  = mk(0, 3'b111, 3'b111, 3'b000, 23'h1000, 0, 3'b000, 3'b000, 0, 0, 0, 23'h0, 3'b000);
        // engines 0 and 2 together: 0 first, one idle cycle, then 2
        tbl[6]  = mk(0, 3'b111, 3'b000, 3'b101, 23'h1000, 0, 3'b000, 3'b000, 0, 1, 1, A0,    3'b000);
        tbl[7]  = mk(0, 3'b111, 3'b000, 3'b101, 23'h1000, 1, 3'b000, 3'b000, 0, 1, 1, A0,    3'b001);
        tbl[8]  = mk(0, 3'b111, 3'b000, 3'b100, 23'h1000, 0, 3'b000, 3'b000, 0, 0, 0, 23'h0, 3'b000);
        tbl[9]  = mk(0, 3'b111, 3'b000, 3'b100, 23'h1000, 0, 3'b000, 3'b000, 0, 3, 1, A2,    3'b000);
        tbl[10] = mk(0, 3'b111, 3'b000, 3'b100, 23'h1000, 1, 3'b000, 3'b000, 0, 3, 1, A2,    3'b100);
        tbl[11] = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b000, 0, 0, 0, 23'h0, 3'b000);
        // engine 1 burst with mid-burst address change
        tbl[12] = mk(0, 3'b111, 3'b000, 3'b010, 23'h1000, 0, 3'b000, 3'b000, 0, 2, 1, 23'h1000, 3'b000);
        tbl[13] = mk(0, 3'b111, 3'b000, 3'b010, 23'h1001, 1, 3'b000, 3'b000, 0, 2, 1, 23'h1001, 3'b010);
        tbl[14] = mk(0, 3'b111, 3'b000, 3'b010, 23'h1001, 0, 3'b000, 3'b000, 0, 2, 1, 23'h1001, 3'b000);
        // busy[1] then a line start: overrun, only 0 and 2 restart
        tbl[15] = mk(1, 3'b010, 3'b000, 3'b010, 23'h1001, 0, 3'b010, 3'b010, 0, 2, 1, 23'h1001, 3'b000);
        tbl[16] = mk(0, 3'b010, 3'b000, 3'b010, 23'h1001, 0, 3'b000, 3'b010, 0, 2, 1, 23'h1001, 3'b000);
        tbl[17] = mk(1, 3'b111, 3'b000, 3'b010, 23'h1001, 0, 3'b101, 3'b111, 1, 2, 1, 23'h1001, 3'b000);
        tbl[18] = mk(0, 3'b111, 3'b000, 3'b010, 23'h1001, 0, 3'b000, 3'b111, 1, 2, 1, 23'h1001, 3'b000);
        // all three requesting: rotation 1 -> 2 -> 0 -> 1
        tbl[19] = mk(0, 3'b111, 3'b000, 3'b111, 23'h1001, 0, 3'b000, 3'b111, 1, 2, 1, 23'h1001, 3'b000);
        tbl[20] = mk(0, 3'b111, 3'b000, 3'b101, 23'h1001, 0, 3'b000, 3'b111, 1, 0, 0, 23'h0,    3'b000);
        tbl[21] = mk(0, 3'b111, 3'b000, 3'b111, 23'h1001, 0, 3'b000, 3'b111, 1, 3, 1, A2,       3'b000);
        tbl[22] = mk(0, 3'b111, 3'b000, 3'b011, 23'h1001, 0, 3'b000, 3'b111, 1, 0, 0, 23'h0,    3'b000);
        tbl[23] = mk(0, 3'b111, 3'b000, 3'b111, 23'h1001, 0, 3'b000, 3'b111, 1, 1, 1, A0,       3'b000);
        tbl[24] = mk(0, 3'b111, 3'b000, 3'b110, 23'h1001, 0, 3'b000, 3'b111, 1, 0, 0, 23'h0,    3'b000);
        tbl[25] = mk(0, 3'b111, 3'b000, 3'b111, 23'h1001, 0, 3'b000, 3'b111, 1, 2, 1, 23'h1001, 3'b000);

        // after reset: clean restart, line start coinciding with qualifying done,
        // then a drop/raise on the same cycle
        post[0] = mk(1, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b111, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[1] = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[2] = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[3] = mk(1, 3'b111, 3'b111, 3'b000, 23'h1000, 0, 3'b111, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[4] = mk(0, 3'b111, 3'b000, 3'b000, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[5] = mk(0, 3'b111, 3'b000, 3'b010, 23'h1000, 0, 3'b000, 3'b111, 0, 2, 1, 23'h1000, 3'b000);
        post[6] = mk(0, 3'b111, 3'b000, 3'b100, 23'h1000, 0, 3'b000, 3'b111, 0, 0, 0, 23'h0, 3'b000);
        post[7] = mk(0, 3'b111, 3'b000, 3'b100, 23'h1000, 0, 3'b000, 3'b111, 0, 3, 1, A2,    3'b000);

        rst_n         = 1'b0;
        lineStart     = 1'b0;
        layerEn       = 3'b000;
        done          = 3'b000;
        bus.req_cs    = 3'b000;
        bus.req_addr0 = A0;
        bus.req_addr1 = 23'h1000;
        bus.req_addr2 = A2;
        bus.mem_data  = 16'h0000;
        bus.mem_ok    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkAllReset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            applyStimulus(tbl[i]);
            checkOutput("tbl", i, tbl[i]);
        end

`ifdef JTCPS1_SCHED_WDOG_EN
        // engine 1 owns and never sees data: released after 16 cycles
        bus.req_cs = 3'b010;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.gnt == 2'd0) begin
                relCyc = n;
                break;
            end
        end
        checkField("wdog_release_cycle", 0, 32'(relCyc), 32'd16);
        checkField("wdog_overrun", 0, 32'(overrunOut), 32'd1);
        @(posedge clk);
        #1;
        checkField("wdog_lockout_gnt", 0, 32'(bus.gnt), 32'd0);
`else
        // engine 1 owns and never sees data: the grant holds
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (bus.gnt !== 2'd2 || bus.mem_cs !== 1'b1) holdBad++;
        end
        checkField("hold_bad_cycles", 0, 32'(holdBad), 32'd0);
        checkField("hold_gnt", 0, 32'(bus.gnt), 32'd2);
`endif

        // asynchronous reset in the middle of a burst
        bus.mem_ok = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkAllReset("async_reset");
        lineStart  = 1'b0;
        done       = 3'b000;
        bus.req_cs = 3'b000;
        bus.mem_ok = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(post[i]);
            checkOutput("post", i, post[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
